// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: one-cycle hits, word-by-word line refill.
// Optional invalidate-all port is compiled in when ICACHE_FLUSH_EN is defined.
module icache #(
    parameter int IDX_W = 6,
    parameter int OFF_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
`ifdef ICACHE_FLUSH_EN
    input  logic        IC_flush,
`endif
    input  logic        IF_pc_sgn,
    input  logic [31:0] IF_pc,
    output logic        IF_ins_sgn,
    output logic [31:0] IF_ins,
    input  logic        ROB_jp_wrong,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_done,
    input  logic [31:0] MC_data
);
    localparam int TAG_W = 30 - IDX_W - OFF_W;
    localparam int LINES = 1 << IDX_W;
    localparam int WORDS = 1 << OFF_W;

    // state | meaning
    // IDLE  | accepting fetches, hits answered next cycle
    // FILL  | refilling req_pc's line from the memory controller
    typedef enum logic {IDLE, FILL} state_t;

    state_t             state;
    logic [31:0]        req_pc;
    logic [OFF_W-1:0]   k;
    logic [OFF_W-1:0]   k_nxt;
    logic               cancel;
    logic               flush_pend;
    logic               flush;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES][WORDS];

    logic [TAG_W-1:0]   pc_tag;
    logic [IDX_W-1:0]   pc_idx;
    logic [OFF_W-1:0]   pc_off;
    logic [TAG_W-1:0]   rq_tag;
    logic [IDX_W-1:0]   rq_idx;
    logic [OFF_W-1:0]   rq_off;
    logic               hit;
    logic               last;
    logic               fill_wr;

`ifdef ICACHE_FLUSH_EN
    assign flush = IC_flush;
`else
    assign flush = 1'b0;
`endif

    assign pc_tag  = IF_pc[31:IDX_W+OFF_W+2];
    assign pc_idx  = IF_pc[IDX_W+OFF_W+1:OFF_W+2];
    assign pc_off  = IF_pc[OFF_W+1:2];
    assign rq_tag  = req_pc[31:IDX_W+OFF_W+2];
    assign rq_idx  = req_pc[IDX_W+OFF_W+1:OFF_W+2];
    assign rq_off  = req_pc[OFF_W+1:2];
    assign hit     = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign last    = &k;
    assign k_nxt   = k + 1'b1;
    assign fill_wr = rst && rdy && (state == FILL) && MC_done;

    // Line storage carries no reset; only the valid bits gate its use.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            data_mem[rq_idx][k] <= MC_data;
            if (last) tag_mem[rq_idx] <= rq_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            valid      <= '0;
            k          <= '0;
            cancel     <= 1'b0;
            flush_pend <= 1'b0;
            req_pc     <= '0;
            IF_ins_sgn <= 1'b0;
            IF_ins     <= '0;
            MC_req     <= 1'b0;
            MC_addr    <= '0;
        end else if (rdy) begin
            IF_ins_sgn <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (IF_pc_sgn && !ROB_jp_wrong) begin
                        if (hit) begin
                            IF_ins_sgn <= 1'b1;
                            IF_ins     <= data_mem[pc_idx][pc_off];
                        end else begin
                            state   <= FILL;
                            req_pc  <= {IF_pc[31:2], 2'b00};
                            k       <= '0;
                            cancel  <= 1'b0;
                            MC_req  <= 1'b1;
                            MC_addr <= {pc_tag, pc_idx, {OFF_W{1'b0}}, 2'b00};
                        end
                    end
                end
                FILL: begin
                    if (ROB_jp_wrong) cancel <= 1'b1;
                    if (flush) flush_pend <= 1'b1;
                    if (MC_done) begin
                        k       <= k_nxt;
                        MC_addr <= {rq_tag, rq_idx, k_nxt, 2'b00};
                        if (last) begin
                            state  <= IDLE;
                            MC_req <= 1'b0;
                            if (flush_pend || flush) begin
                                valid      <= '0;
                                flush_pend <= 1'b0;
                            end else begin
                                valid[rq_idx] <= 1'b1;
                            end
                            // The requested word may be the one arriving right now.
                            if (!cancel && !ROB_jp_wrong) begin
                                IF_ins_sgn <= 1'b1;
                                IF_ins     <= (rq_off == k) ? MC_data : data_mem[rq_idx][rq_off];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus random fetches against a line-level model.
module tb_icache;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        IF_pc_sgn = 1'b0;
    logic [31:0] IF_pc = '0;
    logic        IF_ins_sgn;
    logic [31:0] IF_ins;
    logic        ROB_jp_wrong = 1'b0;
    logic        MC_req;
    logic [31:0] MC_addr;
    logic        MC_done = 1'b0;
    logic [31:0] MC_data = '0;
`ifdef ICACHE_FLUSH_EN
    logic        IC_flush = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    bit          mvalid [64];
    logic [21:0] mtag   [64];

    always #5 clk = ~clk;

    icache dut (
        .clk(clk), .rst(rst), .rdy(rdy),
`ifdef ICACHE_FLUSH_EN
        .IC_flush(IC_flush),
`endif
        .IF_pc_sgn(IF_pc_sgn), .IF_pc(IF_pc), .IF_ins_sgn(IF_ins_sgn), .IF_ins(IF_ins),
        .ROB_jp_wrong(ROB_jp_wrong), .MC_req(MC_req), .MC_addr(MC_addr),
        .MC_done(MC_done), .MC_data(MC_data)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    endtask

    // One fetch held until answered; on a miss the bench plays the memory controller.
    task automatic fetch(input logic [31:0] pc, input int jp_at, input int lat, input int flush_at);
        int          idx;
        logic [21:0] t;
        logic [31:0] base;
        bit          hit;
        bit          fl;
        idx  = int'(pc[9:4]);
        t    = pc[31:10];
        hit  = mvalid[idx] && (mtag[idx] == t);
        fl   = 1'b0;
        IF_pc     = pc;
        IF_pc_sgn = 1'b1;
        step();
        if (hit) begin
            chk("hit_sgn", IF_ins_sgn, 1);
            chk("hit_data", IF_ins, mem_word(pc));
            chk("hit_mcreq", MC_req, 0);
            IF_pc_sgn = 1'b0;
        end else begin
            chk("miss_sgn", IF_ins_sgn, 0);
            chk("miss_mcreq", MC_req, 1);
            base = {pc[31:4], 4'h0};
            for (int j = 0; j < 4; j++) begin
                for (int w = 1; w < lat; w++) begin
                    chk("fill_addr_hold", MC_addr, base + 32'(4 * j));
                    step();
                end
                chk("fill_addr", MC_addr, base + 32'(4 * j));
                chk("fill_req", MC_req, 1);
                MC_done      = 1'b1;
                MC_data      = mem_word(base + 32'(4 * j));
                ROB_jp_wrong = (j == jp_at);
`ifdef ICACHE_FLUSH_EN
                IC_flush     = (j == flush_at);
`endif
                if (j == flush_at) fl = 1'b1;
                step();
                MC_done      = 1'b0;
                ROB_jp_wrong = 1'b0;
`ifdef ICACHE_FLUSH_EN
                IC_flush     = 1'b0;
`endif
                MC_data      = $urandom;
                if (j < 3) chk("fill_nosgn", IF_ins_sgn, 0);
            end
            chk("fill_req_drop", MC_req, 0);
            chk("fill_resp_sgn", IF_ins_sgn, (jp_at < 0) ? 1 : 0);
            if (jp_at < 0) chk("fill_resp_data", IF_ins, mem_word(pc));
            IF_pc_sgn = 1'b0;
            if (fl) model_clear();
            else begin
                mvalid[idx] = 1'b1;
                mtag[idx]   = t;
            end
        end
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] base;
        int          jp;
        model_clear();

        step();
        step();
        chk("rst_sgn", IF_ins_sgn, 0);
        chk("rst_ins", IF_ins, 0);
        chk("rst_req", MC_req, 0);
        chk("rst_addr", MC_addr, 0);
        rst = 1'b1;
        step();

        // Cold miss, forwarded last word, hit streak
        fetch(32'h0000_0010, -1, 2, -1);
        fetch(32'h0000_002C, -1, 2, -1);
        for (int i = 0; i < 4; i++) begin
            IF_pc     = 32'h0000_0010 + 32'(4 * i);
            IF_pc_sgn = 1'b1;
            step();
            chk("streak_sgn", IF_ins_sgn, 1);
            chk("streak_data", IF_ins, mem_word(32'h0000_0010 + 32'(4 * i)));
            chk("streak_mcreq", MC_req, 0);
        end
        IF_pc_sgn = 1'b0;
        step();
        chk("streak_end", IF_ins_sgn, 0);

        // Conflict eviction
        fetch(32'h0000_0410, -1, 1, -1);
        fetch(32'h0000_0010, -1, 3, -1);

        // Redirect mid-fill, then the line hits
        fetch(32'h0000_0080, 1, 2, -1);
        fetch(32'h0000_0084, -1, 2, -1);

        // Redirect in IDLE holds off the hit for a cycle
        IF_pc        = 32'h0000_0088;
        IF_pc_sgn    = 1'b1;
        ROB_jp_wrong = 1'b1;
        step();
        chk("idle_jp_sgn", IF_ins_sgn, 0);
        chk("idle_jp_req", MC_req, 0);
        ROB_jp_wrong = 1'b0;
        step();
        chk("idle_jp_resume", IF_ins_sgn, 1);
        chk("idle_jp_data", IF_ins, mem_word(32'h0000_0088));
        IF_pc_sgn = 1'b0;

        // rdy stall mid-fill, then reset abandons the fill
        base      = 32'h0000_0240;
        IF_pc     = base;
        IF_pc_sgn = 1'b1;
        step();
        chk("stall_req", MC_req, 1);
        for (int j = 0; j < 2; j++) begin
            MC_done = 1'b1;
            MC_data = mem_word(base + 32'(4 * j));
            step();
            MC_done = 1'b0;
        end
        chk("stall_pre_addr", MC_addr, base + 32'h8);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_req_hold", MC_req, 1);
            chk("stall_addr_hold", MC_addr, base + 32'h8);
        end
        rdy     = 1'b1;
        MC_done = 1'b1;
        MC_data = mem_word(base + 32'h8);
        step();
        MC_done = 1'b0;
        chk("stall_k_step", MC_addr, base + 32'hC);
        IF_pc_sgn = 1'b0;
        rst = 1'b0;
        step();
        chk("midrst_req", MC_req, 0);
        chk("midrst_sgn", IF_ins_sgn, 0);
        chk("midrst_addr", MC_addr, 0);
        rst = 1'b1;
        model_clear();
        fetch(base, -1, 2, -1);
        fetch(base + 32'h4, -1, 1, -1);

`ifdef ICACHE_FLUSH_EN
        fetch(32'h0000_0010, -1, 2, -1);
        IC_flush = 1'b1;
        step();
        IC_flush = 1'b0;
        chk("flush_idle_sgn", IF_ins_sgn, 0);
        model_clear();
        fetch(32'h0000_0010, -1, 2, -1);
        fetch(32'h0000_0310, -1, 2, 1);
        fetch(32'h0000_0314, -1, 2, -1);
`endif

        // Random fetches over a small address pool to mix hits, misses and conflicts
        for (int n = 0; n < 80; n++) begin
            pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 1)) << 28)
               | (32'($urandom_range(0, 7)) << 4) | (32'($urandom_range(0, 3)) << 2)
               | 32'($urandom_range(0, 3));
            jp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            fetch(pc, jp, int'($urandom_range(1, 3)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
